intr_ctrl: RTL
==============

# intr_ctrl

Simplified 8259-style programmable interrupt controller that sits directly upstream of the Intel8088 INTR/INTA pins in the top-level system. It collects eight edge-triggered request lines and drives INTR. It answers the processor's two-pulse INTA sequence by placing an 8-bit vector on the shared Data bus, and it is programmed through four I/O-mapped registers on the same bus as the IOM modules.

## Interface
- BASE_RESET, 8'h08: reset value of the vector base register; bits [2:0] are ignored.
- IMR_RESET, 8'hFF: reset value of the interrupt mask register; 1 = masked.
- CLK input 1: system clock; all state updates on posedge.
- RESET input 1: synchronous, active-high reset.
- IR input 8: interrupt requests; IR[0] has the highest priority.
- CS input 1: chip select, active low, from the top-level decode.
- Addr input 2: register offset, taken from latched Address[1:0].
- RD input 1: read strobe, active low.
- WR input 1: write strobe, active low.
- INTA input 1: interrupt acknowledge, active low, from the 8088.
- INTR output 1: interrupt request to the 8088, registered.
- Data inout 8: shared data bus; high-Z unless this block is driving it.

## Operation
- Register map:
  - offset 0: IMR, read/write.
  - offset 1: vector base, read/write; only bits [7:3] are stored.
  - offset 2: write = non-specific EOI, data ignored; read = IRR.
  - offset 3: ISR, read-only; writes are ignored.
- Writes are performed once per bus cycle, on the clock edge where CS=0, WR=0 and the registered WR_q=1 (WR falling edge).
- Reads: Data is driven with the selected register while CS=0 and RD=0 (combinational from registers).
- Request capture: IRR[i] is set on an edge where IR[i]=1 and IR_q[i]=0. Level-held IR does not re-request.
- Pending set: P = IRR & ~IMR.
- Priority block: the lowest-index set ISR bit blocks its own level and every higher index.
- INTR_next = 1 when any P bit has an index below the block level (any P bit if ISR=0) and the state is IDLE.
- State machine (states in a shared enum):
  - IDLE: INTA falling edge (INTA=0, INTA_q=1) → ACK1.
    - Latch SEL = lowest-index P bit, set ISR[SEL], clear IRR[SEL].
    - If P=0 (spurious), SEL=7, VALID=0 and no ISR/IRR change.
    - INTR goes low on the same edge.
  - ACK1: INTA=1 → WAIT2.
  - WAIT2: INTA falling edge → DRIVE.
  - DRIVE: Data = {base[7:3], SEL[2:0]} while INTA=0. INTA=1 → IDLE, Data released.
- EOI clears the lowest-index set ISR bit. With ISR=0 it has no effect.
- Simultaneous events:
  - IR edge and IRR clear on the same bit in the same cycle: the set wins.
  - EOI and ISR set in the same cycle: EOI acts on the pre-edge ISR, then the new bit is set.
  - Register write and request capture in the same cycle: both take effect; the IMR write affects P from the next cycle.
- A register read during DRIVE is a bus conflict and is not defined. The bench must not issue one.

## Timing
- Reset (RESET=1 at posedge):
  - IRR=0, ISR=0, IMR=IMR_RESET, base=BASE_RESET.
  - IR_q=0, WR_q=1, INTA_q=1.
  - State=IDLE, INTR=0, Data=Z.
- Reset mid-acknowledge: return to IDLE and release Data at that edge. No vector is produced.
- Request latency: IR rises before edge k → IRR set at edge k → INTR=1 after edge k+1.
- INTR stays high until the first INTA falling edge is sampled. It can reassert one cycle after returning to IDLE if another request is eligible.
- Vector valid: from the first clock edge with state=DRIVE and INTA=0, held until INTA rises. Data goes high-Z combinationally when INTA rises.
- Write effect: register updated at the WR-falling edge; the read-back value is visible the next cycle.

## Structure
- Package intr_pkg holds:
  - the state enum typedef (IDLE, ACK1, WAIT2, DRIVE);
  - offset constants (OFF_IMR=0, OFF_BASE=1, OFF_EOI_IRR=2, OFF_ISR=3);
  - SPURIOUS_IR=3'd7.
- Sub-module intr_prio: combinational priority resolver. Inputs: 8-bit vector; outputs: valid and a 3-bit index of the lowest set bit. Two instances: one for P, one for ISR.
- Top module: registers, edge detectors, FSM and Data tri-state.

## Test plan
- Reset defaults: after RESET, read offsets 0/1/3 → 8'hFF / 8'h08 / 8'h00. With IMR=FF, pulsing IR[3] leaves INTR=0 and IRR read = 8'h08.
- Single interrupt: write IMR=00, base=8'h20, pulse IR[5]. Required:
  - INTR=1 two edges later.
  - Two INTA pulses → Data=8'h25 during the second pulse.
  - ISR=8'h20, IRR=0.
  - INTR=0 until EOI; EOI → ISR=0.
- Priority and nesting: raise IR[6] and IR[2] on the same edge, then acknowledge. Required:
  - First acknowledge → vector 8'h22, ISR=04.
  - INTR reasserts only after EOI.
  - Second acknowledge → 8'h26.
  - Separately, IR[1] during ISR=04 asserts INTR immediately.
- Spurious: INTR pending from IR[4], then write IMR=8'h10 before INTA. Required: vector 8'h27 and ISR unchanged at 0.
- Level-held request: IR[0] held high through acknowledge and EOI. Required: exactly one interrupt and no re-request.
- Reset mid-acknowledge: assert RESET during WAIT2. Required: Data=Z, INTR=0 and all registers at defaults the following cycle.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// register offsets and the vector index reported for a spurious acknowledge.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        DRIVE = 2'd3
    } state_t;

    localparam logic [1:0] OFF_IMR     = 2'd0;
    localparam logic [1:0] OFF_BASE    = 2'd1;
    localparam logic [1:0] OFF_EOI_IRR = 2'd2;
    localparam logic [1:0] OFF_ISR     = 2'd3;

    localparam logic [2:0] SPURIOUS_IR = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

endpackage

// File: rtl/intr_ctrl_prio.sv
// Combinational priority resolver: reports whether any bit is set and the
// index of the lowest set bit (bit 0 is the highest priority).
module intr_prio (
    input  logic [7:0] req,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) idx = i[2:0];
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Simplified 8259-style interrupt controller: edge-captured requests, masked
// priority resolution, two-pulse INTA vector delivery and I/O register access.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter logic [7:0] BASE_RESET = 8'h08,
    parameter logic [7:0] IMR_RESET  = 8'hFF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IR,
    input  logic       CS,
    input  logic [1:0] Addr,
    input  logic       RD,
    input  logic       WR,
    input  logic       INTA,
    output logic       INTR,
    inout  wire  [7:0] Data,
    output logic [1:0] dbg_state,
    output logic       dbg_drive
);

    state_t     state, state_next;
    logic [7:0] irr, isr, imr;
    logic [4:0] base_hi;
    logic [2:0] sel;
    logic [7:0] ir_q;
    logic       wr_q, inta_q;

    logic [7:0] pending;
    logic       p_valid, isr_valid;
    logic [2:0] p_idx, isr_idx;
    logic       wr_stb, inta_fall, ack, eoi;
    logic [7:0] below_block;
    logic       eligible, intr_next;
    logic [7:0] isr_clr, ack_bit, irr_next, isr_next;
    logic [7:0] data_in, rd_data, data_out;
    logic       vec_drive, rd_drive;

    assign pending = irr & ~imr;

    intr_prio u_prio_pend (
        .req   (pending),
        .valid (p_valid),
        .idx   (p_idx)
    );

    intr_prio u_prio_isr (
        .req   (isr),
        .valid (isr_valid),
        .idx   (isr_idx)
    );

    assign data_in   = Data;
    assign wr_stb    = !CS && !WR && wr_q;
    assign inta_fall = !INTA && inta_q;
    assign ack       = (state == IDLE) && inta_fall;
    assign eoi       = wr_stb && (Addr == OFF_EOI_IRR);

    // The lowest in-service level blocks itself and everything below it in
    // priority; only strictly lower indices may interrupt.
    assign below_block = isr_valid ? (onehot8(isr_idx) - 8'd1) : 8'hFF;
    assign eligible    = |(pending & below_block);
    assign intr_next   = eligible && (state == IDLE) && !inta_fall;

    assign isr_clr  = (eoi && isr_valid) ? onehot8(isr_idx) : 8'h00;
    assign ack_bit  = (ack && p_valid) ? onehot8(p_idx) : 8'h00;
    // A new edge on the same bit as an acknowledge clear keeps the request.
    assign irr_next = (irr & ~ack_bit) | (IR & ~ir_q);
    assign isr_next = (isr & ~isr_clr) | ack_bit;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (inta_fall) state_next = ACK1;
            ACK1:    if (INTA) state_next = WAIT2;
            WAIT2:   if (inta_fall) state_next = DRIVE;
            DRIVE:   if (INTA) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            irr     <= 8'h00;
            isr     <= 8'h00;
            imr     <= IMR_RESET;
            base_hi <= BASE_RESET[7:3];
            sel     <= SPURIOUS_IR;
            ir_q    <= 8'h00;
            wr_q    <= 1'b1;
            inta_q  <= 1'b1;
            INTR    <= 1'b0;
        end else begin
            irr    <= irr_next;
            isr    <= isr_next;
            ir_q   <= IR;
            wr_q   <= WR;
            inta_q <= INTA;
            INTR   <= intr_next;
            if (wr_stb && (Addr == OFF_IMR)) imr <= data_in;
            if (wr_stb && (Addr == OFF_BASE)) base_hi <= data_in[7:3];
            if (ack) sel <= p_valid ? p_idx : SPURIOUS_IR;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        unique case (Addr)
            OFF_IMR:     rd_data = imr;
            OFF_BASE:    rd_data = {base_hi, 3'b000};
            OFF_EOI_IRR: rd_data = irr;
            OFF_ISR:     rd_data = isr;
            default:     rd_data = 8'h00;
        endcase
    end

    // The vector is released combinationally as soon as INTA rises.
    assign vec_drive = (state == DRIVE) && !INTA;
    assign rd_drive  = !CS && !RD;
    assign data_out  = vec_drive ? {base_hi, sel} : rd_data;
    assign Data      = (vec_drive || rd_drive) ? data_out : 8'hzz;

    assign dbg_state = state;
    assign dbg_drive = vec_drive || rd_drive;

endmodule
